cxl_change_monitor: RTL and testbench
=====================================

// Module: cxl_change_monitor
// PURPOSE
// Multi-channel cancel-change monitor: per channel, registers the last (client_id, amount) sample and flags a change.
// Changed samples are held per channel, merged round-robin onto one valid/ready cancel stream for the downstream matcher.
// First valid sample after reset is a change when FIRST_IS_CHANGE=1, so no priming cancel is needed.
// PARAMETERS
// NUM_CH          4   number of input channels (>=1)
// ID_W            5   client_id width
// AMT_W           32  amount width
// FIRST_IS_CHANGE 1   1: first valid sample per channel after reset is reported; 0: only baseline captured
// CNT_W           16  width of coalesce counter (saturating)
// PORTS
// clk            in   1                clock
// rst            in   1                synchronous active-high reset
// in_valid       in   NUM_CH           per-channel sample strobe
// in_client_id   in   NUM_CH*ID_W      ch k at [k*ID_W +: ID_W]
// in_amount      in   NUM_CH*AMT_W     ch k at [k*AMT_W +: AMT_W]
// ack            out  NUM_CH           1-cycle pulse: change detected on ch k
// out_valid      out  1                cancel event available
// out_ready      in   1                consumer accepts when out_valid&out_ready
// out_ch         out  $clog2(NUM_CH)   channel of event (width 1 when NUM_CH=1)
// out_client_id  out  ID_W             client_id of event
// out_amount     out  AMT_W            amount of event
// coalesce_cnt   out  CNT_W            events overwritten while pending, saturates at all-ones
// BEHAVIOUR
// - One clock (clk); reset synchronous active-high (rst). Reset: ack=0, out_valid=0, out_ch/out_client_id/out_amount=0, coalesce_cnt=0, all seen/pending=0, baselines=0.
// - Sampling: only cycles with in_valid[k]=1 are evaluated; idle cycles never raise a change.
// - Change[k] = in_valid[k] & (seen[k] ? (id!=base_id | amt!=base_amt) : FIRST_IS_CHANGE).
// - Every valid sample updates base_id/base_amt and sets seen[k], changed or not.
// - ack[k] asserts exactly cycle t+1 for change at cycle t; one pulse per change.
// - Pending slot per ch: change loads {id,amt}, sets pending[k] at t+1.
// - Change while pending[k]=1 and slot not being drained: overwrite payload (latest wins), coalesce_cnt+1.
// - Change on the cycle slot k is drained: drained value leaves, new value loads, no coalesce count.
// - Output register: when !out_valid | (out_valid & out_ready), grant one pending ch, load outputs, clear its pending.
// - Minimum latency sample->out_valid: 2 cycles (t+1 pending, t+2 out_valid).
// - Full-throughput: out_ready held 1 gives one event per cycle.
// - Round-robin: search starts at last granted ch + 1 mod NUM_CH; after reset pointer = NUM_CH-1 (ch 0 first).
// - out_* stable while out_valid=1 & out_ready=0 (AXI-style; valid never drops without handshake).
// - No events lost except by coalescing; coalesce_cnt is the only loss indicator.
// - rst mid-operation: pending events and held output discarded; next cycle equals reset state.
// STRUCTURE
// - cxl_pkg: CXL_ID_W, CXL_AMT_W defaults; typedef struct packed {id; amount;} cxl_cancel_t; ch_idx_t.
// - Sub-module rr_arbiter #(N): req[N], advance, grant one-hot + index; pointer updates only on advance.
// - Top: generate loop of per-channel baseline/seen/pending regs; output register stage; coalesce counter.
// TESTING
// - Reset then ch0 valid id=3 amt=100 (FIRST_IS_CHANGE=1) -> ack[0] at t+1; out_valid t+2 with ch=0,id=3,amt=100.
// - Repeat ch0 id=3 amt=100 -> no ack, no event; then amt=101 -> ack[0], event amt=101.
// - All 4 ch change same cycle, out_ready=1 -> 4 events on consecutive cycles, order ch0,1,2,3.
// - out_ready=0, ch1 changes amt 5,6,7 on 3 cycles -> one event amt=7 (or 5 if already in output reg), coalesce_cnt as computed.
// - out_ready=0 for 10 cycles with out_valid=1 -> out_* constant; then ready=1 -> handshake once, next event follows.
// - rst asserted with 3 pending events -> next cycle out_valid=0, ack=0, coalesce_cnt=0; FIRST_IS_CHANGE=0 run: first sample no ack.

Source files
------------

// File: rtl/cxl_change_monitor_pkg.sv
// Shared widths, payload type and index helper for the cancel-change monitor.
package cxl_pkg;

    localparam int unsigned CXL_ID_W   = 5;
    localparam int unsigned CXL_AMT_W  = 32;
    localparam int unsigned CXL_NUM_CH = 4;

    // Index width that stays at least one bit for a single-channel build.
    function automatic int unsigned cxl_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [CXL_ID_W-1:0]  id;
        logic [CXL_AMT_W-1:0] amount;
    } cxl_cancel_t;

    typedef logic [cxl_idx_w(CXL_NUM_CH)-1:0] ch_idx_t;

endpackage

// File: rtl/cxl_change_monitor_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index.
module rr_arbiter
    import cxl_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = cxl_idx_w(N)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic             advance_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] cand;
    int unsigned      idx;

    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        idx           = 0;
        cand          = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx  = (32'(ptr_q) + off) % N;
            cand = IDX_W'(idx);
            if (!grant_valid_o && req_i[cand]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = cand;
            end
        end
        if (grant_valid_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && grant_valid_o) begin
            ptr_d = grant_idx_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= IDX_W'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cxl_change_monitor.sv
// Per-channel change detection with latest-wins pending slots, merged
// round-robin into one registered valid/ready cancel stream.
module cxl_change_monitor
    import cxl_pkg::*;
#(
    parameter  int unsigned NUM_CH          = CXL_NUM_CH,
    parameter  int unsigned ID_W            = CXL_ID_W,
    parameter  int unsigned AMT_W           = CXL_AMT_W,
    parameter  int unsigned FIRST_IS_CHANGE = 1,
    parameter  int unsigned CNT_W           = 16,
    localparam int unsigned CH_W            = cxl_idx_w(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*ID_W-1:0]  in_client_id,
    input  logic [NUM_CH*AMT_W-1:0] in_amount,
    output logic [NUM_CH-1:0]       ack,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic [ID_W-1:0]         out_client_id,
    output logic [AMT_W-1:0]        out_amount,
    output logic [CNT_W-1:0]        coalesce_cnt
);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [AMT_W-1:0] amount;
    } sample_t;

    localparam logic FIC = (FIRST_IS_CHANGE != 0);

    logic [NUM_CH-1:0] change;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] drain;
    logic [NUM_CH-1:0] coal;
    sample_t           slot_arr [NUM_CH];

    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_valid;
    logic              load;

    logic [NUM_CH-1:0] ack_q;
    logic              out_valid_q;
    logic [CH_W-1:0]   out_ch_q;
    sample_t           out_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W:0]    cnt_sum;

    assign load  = ~out_valid_q | out_ready;
    assign drain = grant & {NUM_CH{load}};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        sample_t smp;
        sample_t base_q;
        sample_t slot_q;
        logic    seen_q;
        logic    pend_q;
        logic    pend_d;

        assign smp.id     = in_client_id[k*ID_W +: ID_W];
        assign smp.amount = in_amount[k*AMT_W +: AMT_W];
        assign change[k]  = in_valid[k] & (seen_q ? (smp != base_q) : FIC);
        // A change landing on the drain cycle refills the slot rather than coalescing.
        assign coal[k]    = change[k] & pend_q & ~drain[k];
        assign pend_d     = change[k] | (pend_q & ~drain[k]);
        assign pending[k] = pend_q;
        assign slot_arr[k] = slot_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                base_q <= '0;
                slot_q <= '0;
                seen_q <= 1'b0;
                pend_q <= 1'b0;
            end else begin
                if (in_valid[k]) begin
                    base_q <= smp;
                    seen_q <= 1'b1;
                end
                if (change[k]) begin
                    slot_q <= smp;
                end
                pend_q <= pend_d;
            end
        end
    end

    rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (pending),
        .advance_i     (load),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    always_comb begin
        cnt_sum = (CNT_W+1)'(cnt_q) + (CNT_W+1)'($countones(coal));
        cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_q       <= '0;
            cnt_q       <= '0;
        end else begin
            ack_q <= change;
            cnt_q <= cnt_d;
            if (load) begin
                out_valid_q <= grant_valid;
                if (grant_valid) begin
                    out_ch_q <= grant_idx;
                    out_q    <= slot_arr[grant_idx];
                end
            end
        end
    end

    assign ack           = ack_q;
    assign out_valid     = out_valid_q;
    assign out_ch        = out_ch_q;
    assign out_client_id = out_q.id;
    assign out_amount    = out_q.amount;
    assign coalesce_cnt  = cnt_q;

endmodule

// File: tb/tb_cxl_change_monitor.sv
// Directed bench for cxl_change_monitor: event-level model per instance plus literal pins.
module tb_cxl_change_monitor;

    logic         clk;
    logic         rst;
    logic [3:0]   in_valid;
    logic [19:0]  in_client_id;
    logic [127:0] in_amount;
    logic         out_ready;
    logic [4:0]   sid  [4];
    logic [31:0]  samt [4];

    logic [3:0]  ack_a,  ack_b;
    logic        ov_a,   ov_b;
    logic [1:0]  ch_a,   ch_b;
    logic [4:0]  id_a,   id_b;
    logic [31:0] amt_a,  amt_b;
    logic [15:0] cnt_a,  cnt_b;

    int errs   = 0;
    int checks = 0;
    bit started = 0;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            in_client_id[k*5 +: 5]  = sid[k];
            in_amount[k*32 +: 32]   = samt[k];
        end
    end

    cxl_change_monitor #(
        .NUM_CH(4), .ID_W(5), .AMT_W(32), .FIRST_IS_CHANGE(1), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_client_id(in_client_id),
        .in_amount(in_amount), .ack(ack_a), .out_valid(ov_a), .out_ready(out_ready),
        .out_ch(ch_a), .out_client_id(id_a), .out_amount(amt_a), .coalesce_cnt(cnt_a)
    );

    cxl_change_monitor #(
        .NUM_CH(4), .ID_W(5), .AMT_W(32), .FIRST_IS_CHANGE(0), .CNT_W(16)
    ) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_client_id(in_client_id),
        .in_amount(in_amount), .ack(ack_b), .out_valid(ov_b), .out_ready(out_ready),
        .out_ch(ch_b), .out_client_id(id_b), .out_amount(amt_b), .coalesce_cnt(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Event-level model: index 0 = FIRST_IS_CHANGE=1 instance, 1 = FIRST_IS_CHANGE=0.
    bit          m_seen [2][4];
    bit          m_pend [2][4];
    logic [4:0]  m_bid  [2][4];
    logic [31:0] m_bamt [2][4];
    logic [4:0]  m_sid  [2][4];
    logic [31:0] m_samt [2][4];
    int          m_ptr  [2];
    logic [3:0]  m_ack  [2];
    bit          m_ov   [2];
    int          m_och  [2];
    logic [4:0]  m_oid  [2];
    logic [31:0] m_oamt [2];
    int          m_cnt  [2];

    task automatic model_reset(input int m);
        for (int k = 0; k < 4; k++) begin
            m_seen[m][k] = 0; m_pend[m][k] = 0;
            m_bid[m][k] = '0; m_bamt[m][k] = '0;
            m_sid[m][k] = '0; m_samt[m][k] = '0;
        end
        m_ptr[m] = 3; m_ack[m] = '0; m_ov[m] = 0;
        m_och[m] = 0; m_oid[m] = '0; m_oamt[m] = '0; m_cnt[m] = 0;
    endtask

    task automatic model_step(input int m, input bit fic);
        bit         load;
        int         g;
        logic [3:0] chg;
        load = !m_ov[m] || out_ready;
        g = -1;
        if (load) begin
            for (int off = 1; off <= 4; off++) begin
                int idx = (m_ptr[m] + off) % 4;
                if (g < 0 && m_pend[m][idx]) g = idx;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (!in_valid[k]) chg[k] = 1'b0;
            else if (m_seen[m][k]) chg[k] = (sid[k] != m_bid[m][k]) || (samt[k] != m_bamt[m][k]);
            else chg[k] = fic;
            if (chg[k] && m_pend[m][k] && k != g && m_cnt[m] < 65535) m_cnt[m]++;
        end
        if (load) begin
            if (g >= 0) begin
                m_ov[m] = 1; m_och[m] = g;
                m_oid[m] = m_sid[m][g]; m_oamt[m] = m_samt[m][g];
                m_ptr[m] = g; m_pend[m][g] = 0;
            end else begin
                m_ov[m] = 0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (in_valid[k]) begin
                m_bid[m][k] = sid[k]; m_bamt[m][k] = samt[k]; m_seen[m][k] = 1;
            end
            if (chg[k]) begin
                m_sid[m][k] = sid[k]; m_samt[m][k] = samt[k]; m_pend[m][k] = 1;
            end
        end
        m_ack[m] = chg;
    endtask

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rst) model_reset(m);
            else model_step(m, (m == 0));
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("a.ack", 64'(ack_a), 64'(m_ack[0]));
            chk("a.out_valid", 64'(ov_a), 64'(m_ov[0]));
            chk("a.coalesce_cnt", 64'(cnt_a), 64'(m_cnt[0]));
            if (m_ov[0]) begin
                chk("a.out_ch", 64'(ch_a), 64'(m_och[0]));
                chk("a.out_client_id", 64'(id_a), 64'(m_oid[0]));
                chk("a.out_amount", 64'(amt_a), 64'(m_oamt[0]));
            end
            chk("b.ack", 64'(ack_b), 64'(m_ack[1]));
            chk("b.out_valid", 64'(ov_b), 64'(m_ov[1]));
            chk("b.coalesce_cnt", 64'(cnt_b), 64'(m_cnt[1]));
            if (m_ov[1]) begin
                chk("b.out_ch", 64'(ch_b), 64'(m_och[1]));
                chk("b.out_client_id", 64'(id_b), 64'(m_oid[1]));
                chk("b.out_amount", 64'(amt_b), 64'(m_oamt[1]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin sid[k] = '0; samt[k] = '0; end
        cyc(2);
        chk("lit.reset_ack", 64'(ack_a), 64'd0);
        chk("lit.reset_out_valid", 64'(ov_a), 64'd0);
        chk("lit.reset_cnt", 64'(cnt_a), 64'd0);

        // First sample after reset
        rst = 1'b0;
        sid[0] = 5'd3; samt[0] = 32'd100; in_valid = 4'b0001;
        cyc(1);
        chk("lit.first_ack", 64'(ack_a), 64'h1);
        chk("lit.first_ack_fic0", 64'(ack_b), 64'h0);
        in_valid = '0;
        cyc(1);
        chk("lit.first_ov", 64'(ov_a), 64'd1);
        chk("lit.first_ch", 64'(ch_a), 64'd0);
        chk("lit.first_id", 64'(id_a), 64'd3);
        chk("lit.first_amt", 64'(amt_a), 64'd100);
        cyc(1);

        // Repeat identical sample, then a changed amount
        in_valid = 4'b0001;
        cyc(1);
        chk("lit.repeat_ack", 64'(ack_a), 64'h0);
        in_valid = '0;
        cyc(1);
        chk("lit.repeat_no_event", 64'(ov_a), 64'd0);
        samt[0] = 32'd101; in_valid = 4'b0001;
        cyc(1);
        chk("lit.amt101_ack", 64'(ack_a), 64'h1);
        in_valid = '0;
        cyc(1);
        chk("lit.amt101_amt", 64'(amt_a), 64'd101);
        cyc(1);

        // Park the pointer on ch3 so the next burst starts at ch0
        sid[3] = 5'd9; samt[3] = 32'd9; in_valid = 4'b1000;
        cyc(1);
        in_valid = '0;
        cyc(3);

        for (int k = 0; k < 4; k++) begin sid[k] = 5'(k + 1); samt[k] = 32'(10 * (k + 1)); end
        in_valid = 4'b1111;
        cyc(1);
        chk("lit.burst_ack", 64'(ack_a), 64'hf);
        in_valid = '0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("lit.burst_ch", 64'(ch_a), 64'(i));
            chk("lit.burst_amt", 64'(amt_a), 64'(10 * (i + 1)));
        end
        cyc(1);
        chk("lit.burst_drained", 64'(ov_a), 64'd0);

        // Coalescing on ch1 with the consumer stalled
        out_ready = 1'b0;
        sid[1] = 5'd2; samt[1] = 32'd5; in_valid = 4'b0010;
        cyc(1);
        samt[1] = 32'd6;
        cyc(1);
        chk("lit.stall_amt5", 64'(amt_a), 64'd5);
        samt[1] = 32'd7;
        cyc(1);
        chk("lit.coalesce_cnt", 64'(cnt_a), 64'd1);
        in_valid = '0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("lit.stall_hold_valid", 64'(ov_a), 64'd1);
            chk("lit.stall_hold_amt", 64'(amt_a), 64'd5);
        end
        out_ready = 1'b1;
        cyc(1);
        chk("lit.next_ch", 64'(ch_a), 64'd1);
        chk("lit.next_amt", 64'(amt_a), 64'd7);
        cyc(1);
        chk("lit.after_next", 64'(ov_a), 64'd0);

        // Reset with three events still pending
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) samt[k] = 32'(10 * (k + 1) + 1);
        in_valid = 4'b1111;
        cyc(1);
        in_valid = '0;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        chk("lit.midrst_ov", 64'(ov_a), 64'd0);
        chk("lit.midrst_ack", 64'(ack_a), 64'd0);
        chk("lit.midrst_cnt", 64'(cnt_a), 64'd0);
        rst = 1'b0; out_ready = 1'b1;
        cyc(1);

        sid[2] = 5'd7; samt[2] = 32'd70; in_valid = 4'b0100;
        cyc(1);
        chk("lit.post_rst_ack", 64'(ack_a), 64'h4);
        chk("lit.post_rst_ack_fic0", 64'(ack_b), 64'h0);
        in_valid = '0;
        cyc(3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
